arbitro_1: RTL
==============

ARBITRO_1 -- requirements
Module: arbitro_1

Interface
REQ-001 Parameter WIDTH, default 6, SHALL set the word width of all data ports.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  input  1  SHALL be asynchronous, active-low reset (0 = reset asserted).
REQ-004 Enable  input  1  SHALL permit issuing new pops when 1.
REQ-005 FIFO_empty  input  4  SHALL give per-class source FIFO empty flags, bit i = class i.
REQ-006 Almost_full  input  1  SHALL be the almost-full flag of the single destination FIFO.
REQ-007 data_in0..data_in3  input  WIDTH each  SHALL be the read data of source FIFOs 0..3.
REQ-008 Pop  output  4  SHALL be registered one-hot pop strobes, bit i = FIFO i.
REQ-009 Push  output  1  SHALL be the registered push strobe to the destination FIFO.
REQ-010 data_out  output  WIDTH  SHALL be the registered word written with Push.
REQ-011 class_out  output  2  SHALL give the source class of the word on data_out.
REQ-012 idle  output  1  SHALL be 1 when no pop or push is in flight and all FIFO_empty bits are 1.

Function
REQ-013 Queue i SHALL be eligible at an edge when: reset=1, Enable=1, Almost_full=0, FIFO_empty[i]=0, and Pop[i] is currently 0.
REQ-014 Grant SHALL be round-robin: search starts at pointer rr (2 bits), ascending modulo 4; the first eligible queue wins; no fixed priority.
REQ-015 On a grant to queue g, Pop SHALL become 1<<g for exactly one cycle and rr SHALL become (g+1) mod 4; with no grant Pop=0 and rr holds.
REQ-016 Pop SHALL be at most one-hot; a queue SHALL never be popped on two consecutive cycles (guards stale FIFO_empty).
REQ-017 Source FIFO i drives valid data on data_in_i in the cycle after Pop[i]=1; at the end of that cycle the block SHALL capture it: data_out<=data_in_g, class_out<=g, Push<=1.
REQ-018 Latency SHALL be fixed: Push high exactly 2 cycles after the corresponding Pop high; Push=0 in every cycle with no matching Pop two cycles earlier.
REQ-019 Pipeline SHALL hold ≤2 in-flight words (pop stage, data stage), tracked by registered valid bit and 2-bit class tag per stage.
REQ-020 Word order on the output SHALL equal grant order; no word dropped or duplicated.
REQ-021 Almost_full=1 or Enable=0 SHALL block only new grants; in-flight words SHALL still complete their Push (destination threshold covers 2 words).
REQ-022 data_out and class_out SHALL hold their last value while Push=0.
REQ-023 Throughput: ≥2 non-empty queues → one Push per cycle; exactly one non-empty queue → one Push per 2 cycles.
REQ-024 idle SHALL be registered, computed from both stage valid bits, Pop and FIFO_empty.

Reset
REQ-025 reset=0 SHALL immediately force Pop=0, Push=0, data_out=0, class_out=0, rr=0, stage valid bits=0, idle=1, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard in-flight words (no Push after release).
REQ-027 First grant after reset release SHALL be evaluated at the first posedge with reset=1, starting search at queue 0.

Verification
REQ-028 All four queues non-empty, Enable=1, Almost_full=0 -> Pop sequence 0001,0010,0100,1000,0001...; Push continuous from cycle 3, class_out 0,1,2,3,0.
REQ-029 Only queue 2 non-empty with words 0x15,0x2A -> Pop=0100 on alternate cycles; Push pulses carry 0x15 then 0x2A, class_out=2, 2 cycles after each Pop.
REQ-030 Almost_full raised the cycle after a Pop -> no further Pop; the 1-2 in-flight words still pushed; grants resume from rr the cycle after Almost_full=0.
REQ-031 Enable=0 with all queues non-empty -> Pop=0 throughout, in-flight words pushed, idle=0; Enable=1 -> round-robin resumes at stored rr.
REQ-032 reset=0 asserted asynchronously between Pop and Push -> outputs 0 immediately, no Push after release, first Pop targets lowest non-empty queue from 0.

Source files
------------

// File: rtl/arbitro_1.sv
// arbitro_1: round-robin arbiter that pops four class source FIFOs and forwards
// each popped word into a single destination FIFO after a fixed 2-cycle latency.
//
// Ports:
//   clk            clock, all state on posedge
//   reset          asynchronous active-low reset
//   Enable         permits new pops when 1
//   FIFO_empty[3:0] per-class source empty flags (bit i = class i)
//   Almost_full    destination almost-full, blocks new pops only
//   data_in0..3    source FIFO read data, valid the cycle after its Pop
//   Pop[3:0]       registered one-hot pop strobes
//   Push           registered push strobe to destination
//   data_out       registered word written with Push (holds otherwise)
//   class_out      source class of data_out (holds otherwise)
//   idle           registered: nothing in flight and all sources empty
module arbitro_1 #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [3:0]       FIFO_empty,
    input  logic             Almost_full,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    output logic [3:0]       Pop,
    output logic             Push,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       class_out,
    output logic             idle
);

    localparam int unsigned NQ    = 4;
    localparam int unsigned CLS_W = 2;

    logic [CLS_W-1:0] rr;
    logic             p_vld;
    logic [CLS_W-1:0] p_cls;
    logic             d_vld;
    logic [CLS_W-1:0] d_cls;

    logic [NQ-1:0]    elig_c;
    logic             grant_c;
    logic [CLS_W-1:0] gnt_c;
    logic [CLS_W-1:0] idx_c;
    logic [WIDTH-1:0] sel_data_c;

    // Eligibility excludes the queue popped last cycle: its empty flag is stale.
    always_comb begin
        elig_c = '0;
        if (Enable && !Almost_full) begin
            elig_c = ~FIFO_empty & ~Pop;
        end
    end

    // Round-robin search from rr; scanning offsets high-to-low lets the
    // smallest offset win last.
    always_comb begin
        grant_c = 1'b0;
        gnt_c   = rr;
        idx_c   = rr;
        for (int k = NQ - 1; k >= 0; k--) begin
            idx_c = rr + CLS_W'(k);
            if (elig_c[idx_c]) begin
                grant_c = 1'b1;
                gnt_c   = idx_c;
            end
        end
    end

    // Select the source whose data is valid this cycle (popped last cycle).
    always_comb begin
        sel_data_c = data_in0;
        case (d_cls)
            2'd0:    sel_data_c = data_in0;
            2'd1:    sel_data_c = data_in1;
            2'd2:    sel_data_c = data_in2;
            default: sel_data_c = data_in3;
        endcase
    end

    // Pop stage -> data stage -> push register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Pop       <= '0;
            Push      <= 1'b0;
            data_out  <= '0;
            class_out <= '0;
            rr        <= '0;
            p_vld     <= 1'b0;
            p_cls     <= '0;
            d_vld     <= 1'b0;
            d_cls     <= '0;
            idle      <= 1'b1;
        end else begin
            Pop   <= grant_c ? (4'b0001 << gnt_c) : 4'b0000;
            p_vld <= grant_c;
            p_cls <= gnt_c;
            if (grant_c) begin
                rr <= gnt_c + CLS_W'(1);
            end
            d_vld <= p_vld;
            d_cls <= p_cls;
            Push  <= d_vld;
            if (d_vld) begin
                data_out  <= sel_data_c;
                class_out <= d_cls;
            end
            idle <= !p_vld && !d_vld && (Pop == 4'b0000) && (&FIFO_empty);
        end
    end

endmodule
